// File: rtl/memory_module.sv
// Synchronous data memory: DEPTH words of DATA_W bits, one write port, one registered read port.
// Optional macro MEM_BYPASS_EN selects write-first same-index behaviour; the default is read-first.
module memory_module #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readAddress,
  output logic [DATA_W-1:0] readData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_read_data;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic [DATA_W-1:0] w_read_word;

  // Addresses wrap modulo DEPTH; the upper bits are intentionally dropped.
  assign w_wr_idx = writeAddress[AW-1:0];
  assign w_rd_idx = readAddress[AW-1:0];

  generate
    if (AW < DATA_W) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^{writeAddress[DATA_W-1:AW], readAddress[DATA_W-1:AW]};
    end
  endgenerate

`ifdef MEM_BYPASS_EN
  assign w_read_word = (MemWrite && (w_wr_idx == w_rd_idx)) ? writeData : r_mem[w_rd_idx];
`else
  assign w_read_word = r_mem[w_rd_idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_read_data <= '0;
    end else begin
      if (MemWrite) begin
        r_mem[w_wr_idx] <= writeData;
      end
      if (MemRead) begin
        r_read_data <= w_read_word;
      end
    end
  end

  assign readData = r_read_data;

endmodule

// File: tb/tb_memory_module.sv
// Directed bench for memory_module: an array-based reference model is checked every cycle,
// alongside hand-computed literal expectations for the key scenarios.
module tb_memory_module;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [DATA_W-1:0] writeAddress = '0;
  logic [DATA_W-1:0] writeData = '0;
  logic [DATA_W-1:0] readAddress = '0;
  logic [DATA_W-1:0] readData;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd = '0;

  memory_module #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .readAddress  (readAddress),
    .readData     (readData)
  );

  always #5 clk = ~clk;

  always @(posedge reset) begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rd = '0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      int wi, ri;
      wi = int'(writeAddress) % DEPTH;
      ri = int'(readAddress) % DEPTH;
      if (MemRead) begin
`ifdef MEM_BYPASS_EN
        if (MemWrite && wi == ri) m_rd = writeData;
        else                      m_rd = m_mem[ri];
`else
        m_rd = m_mem[ri];
`endif
      end
      if (MemWrite) m_mem[wi] = writeData;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (readData !== m_rd) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t readData=%h expected=%h", $time, readData, m_rd);
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] exp);
    vectors++;
    if (readData !== exp) begin
      miscompares++;
      $display("FAIL %s readData=%h expected=%h", name, readData, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [DATA_W-1:0] ra,
                     input logic [DATA_W-1:0] wa, input logic [DATA_W-1:0] wd);
    @(negedge clk);
    #1;
    MemRead = rd;
    MemWrite = wr;
    readAddress = ra;
    writeAddress = wa;
    writeData = wd;
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] same_edge_exp;

  initial begin
`ifdef MEM_BYPASS_EN
    same_edge_exp = 16'hBEEF;
`else
    same_edge_exp = 16'h0000;
`endif
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    check("reset_state", 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    cyc(1, 0, 16'h0000, 16'h0000, 16'h0000); check("read_after_reset", 16'h0000);
    cyc(0, 1, 16'h0000, 16'h000A, 16'hFFFF); check("write_no_read_holds", 16'h0000);
    cyc(1, 0, 16'h000A, 16'h0000, 16'h0000); check("read_0A", 16'hFFFF);
    cyc(1, 0, 16'h000B, 16'h0000, 16'h0000); check("read_0B", 16'h0000);
    cyc(1, 0, 16'h000A, 16'h0000, 16'h0000); check("reread_0A", 16'hFFFF);
    cyc(0, 0, 16'h0033, 16'h0000, 16'h0000); check("hold_on_memread_low", 16'hFFFF);
    cyc(1, 1, 16'h0005, 16'h0005, 16'hBEEF); check("same_edge_rw", same_edge_exp);
    cyc(1, 0, 16'h0005, 16'h0000, 16'h0000); check("read_after_same_edge", 16'hBEEF);
    cyc(1, 1, 16'h000A, 16'h0020, 16'h1111); check("rw_diff_addr", 16'hFFFF);
    cyc(1, 0, 16'h0020, 16'h0000, 16'h0000); check("read_0x20", 16'h1111);
    cyc(0, 1, 16'h0000, 16'h010A, 16'h1234); check("wrap_write_hold", 16'h1111);
    cyc(1, 0, 16'h000A, 16'h0000, 16'h0000); check("wrap_read_0A", 16'h1234);
    cyc(1, 0, 16'hFF0A, 16'h0000, 16'h0000); check("wrap_read_FF0A", 16'h1234);
    cyc(0, 1, 16'h0000, 16'h050A, 16'hFFFF);
    cyc(1, 0, 16'h000A, 16'h0000, 16'h0000); check("restore_0A", 16'hFFFF);
    cyc(1, 0, 16'h00FF, 16'h0000, 16'h0000); check("top_index", 16'h0000);

    // Asynchronous reset between edges, with a write attempted while it is held.
    MemRead = 1'b0;
    MemWrite = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset_immediate", 16'h0000);
    @(negedge clk);
    MemRead = 1'b1;
    MemWrite = 1'b1;
    writeAddress = 16'h000A;
    writeData = 16'h5555;
    readAddress = 16'h000A;
    @(posedge clk);
    #1 check("reset_held_output", 16'h0000);
    @(negedge clk);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    reset = 1'b0;
    cyc(1, 0, 16'h000A, 16'h0000, 16'h0000); check("post_reset_0A", 16'h0000);
    cyc(1, 0, 16'h0005, 16'h0000, 16'h0000); check("post_reset_05", 16'h0000);
    cyc(1, 0, 16'h0020, 16'h0000, 16'h0000); check("post_reset_20", 16'h0000);
    cyc(0, 0, 16'h0000, 16'h0000, 16'h0000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
